// File: rtl/toothless_pkg.sv
// toothless_pkg: shared fetch-stage types and constants
package toothless_pkg;
  typedef enum logic [1:0] {FETCH_BOOT, FETCH_RUN, FETCH_DRAIN} fetch_state_e;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO with flush; the head entry comes straight from the storage registers
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  assign dout = mem[rd];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) mem[wr] <= din;
      wr <= wr + AW'(push);
      rd <= rd + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop && !flush));
  assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty && !flush));
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end with prefetch FIFO and redirect handling
module fetch_stage
  import toothless_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   instr_req_o,
  output logic [ADDR_WIDTH-1:0]  instr_addr_o,
  input  logic                   instr_gnt_i,
  input  logic                   instr_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] instr_rdata_i,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_addr_i,
  output logic                   instr_valid_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  instr_pc_o,
  input  logic                   instr_ready_i,
  output logic                   misaligned_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_e state;
  logic [ADDR_WIDTH-1:0] fetch_addr, out_pc;
  logic [INSTR_WIDTH+ADDR_WIDTH-1:0] head;
  logic [CW-1:0] count, credit;
  logic outstanding, discard, retire, fire, next_out, push, pop, full, empty;
  assign pop = instr_valid_o & instr_ready_i;
  assign retire = outstanding & instr_rvalid_i;
  // a popping head frees its slot this cycle, so the stream can sustain one word per cycle
  assign credit = count - CW'(pop) + CW'(outstanding);
  assign instr_req_o = state == FETCH_RUN && (!outstanding || retire) && credit < CW'(FIFO_DEPTH);
  assign fire = instr_req_o & instr_gnt_i;
  assign next_out = (outstanding & ~instr_rvalid_i) | fire;
  assign push = retire & ~discard & ~redirect_i;
  assign instr_addr_o = fetch_addr;
  assign instr_valid_o = ~empty;
  assign {instr_o, instr_pc_o} = head;
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(INSTR_WIDTH + ADDR_WIDTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .flush(redirect_i),
    .din({instr_rdata_i, out_pc}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH_BOOT;
      fetch_addr <= BOOT_ADDR;
      out_pc <= '0;
      outstanding <= 1'b0;
      discard <= 1'b0;
      misaligned_o <= 1'b0;
    end else begin
      misaligned_o <= redirect_i && |redirect_addr_i[1:0];
      outstanding <= next_out;
      if (fire) out_pc <= fetch_addr;
      fetch_addr <= redirect_i ? {redirect_addr_i[ADDR_WIDTH-1:2], 2'b00} :
                    fire ? fetch_addr + ADDR_WIDTH'(4) : fetch_addr;
      // whatever is still in flight after a redirect belongs to the old path
      discard <= redirect_i ? next_out : discard & outstanding & ~instr_rvalid_i;
      state <= state == FETCH_BOOT ? FETCH_RUN :
               redirect_i ? (next_out ? FETCH_DRAIN : FETCH_RUN) :
               (state == FETCH_DRAIN && instr_rvalid_i) ? FETCH_RUN : state;
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n)
    !(instr_rvalid_i && !outstanding && state != FETCH_BOOT));
  assert property (@(posedge clk) disable iff (!rst_n) !(full && outstanding));
endmodule
